// File: rtl/disp_pkg.sv
// Shared register map, bit positions and masks for the display register-control block.
package disp_pkg;
    localparam logic [15:0] DISP_BASE         = 16'h2000;

    localparam logic [7:0]  OFF_CTRL          = 8'h00;
    localparam logic [7:0]  OFF_FB_PEND       = 8'h04;
    localparam logic [7:0]  OFF_FB_ACTIVE     = 8'h08;
    localparam logic [7:0]  OFF_STATUS        = 8'h0C;
    localparam logic [7:0]  OFF_FRAME_CNT     = 8'h10;
    localparam logic [7:0]  OFF_UNDERFLOW_CNT = 8'h14;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int STAT_VBLANK   = 0;
    localparam int STAT_UPD_PEND = 1;

    localparam int UFLOW_W = 16;

    localparam logic [31:0] CTRL_MASK = 32'h0000_0003;
    localparam logic [31:0] FB_MASK   = 32'hFFFF_FFF8;

    function automatic logic win_hit(input logic [15:0] addr);
        return addr[15:8] == DISP_BASE[15:8];
    endfunction
endpackage

// File: rtl/disp_regctrl_if.sv
// Host register-bus signals for the display control window.
interface disp_regctrl_if;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;

    modport master (output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, input RDATA);
    modport slave  (input WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, output RDATA);
endinterface

// File: rtl/regbus_bytewrite.sv
// Byte-lane merged storage; bits cleared in MASK always hold 0.
module regbus_bytewrite #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] MASK   = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     q
);
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = q;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= merged & MASK;
    end
endmodule

// File: rtl/disp_regctrl.sv
// Display register control: framebuffer double-buffer latched at vblank,
// frame/underflow counters, sticky vblank status and maskable interrupt.
module disp_regctrl
    import disp_pkg::*;
(
    input  logic                ACLK,
    input  logic                ARESETN,
    disp_regctrl_if.slave       bus,
    input  logic                vblank_start,
    input  logic                underflow,
    output logic                disp_enable,
    output logic [31:0]         fb_addr,
    output logic                irq
);
    logic               wr_hit;
    logic [7:0]         wr_off;
    logic               ctrl_we, fbp_we, stat_we, ufc_we;
    logic [31:0]        ctrl_q, fb_pend;
    logic               upd_pend, vblank;
    logic [31:0]        frame_cnt;
    logic [UFLOW_W-1:0] uflow_cnt;
    logic [31:0]        rd_val, rdata;

    assign wr_hit  = bus.WREN && win_hit(bus.WRADDR);
    assign wr_off  = bus.WRADDR[7:0];
    assign ctrl_we = wr_hit && (wr_off == OFF_CTRL);
    assign fbp_we  = wr_hit && (wr_off == OFF_FB_PEND);
    assign stat_we = wr_hit && (wr_off == OFF_STATUS);
    assign ufc_we  = wr_hit && (wr_off == OFF_UNDERFLOW_CNT);

    regbus_bytewrite #(.DATA_W(32), .MASK(CTRL_MASK)) u_ctrl (
        .clk(ACLK), .rst_n(ARESETN), .we(ctrl_we), .be(bus.BYTEEN),
        .wdata(bus.WDATA), .q(ctrl_q)
    );

    regbus_bytewrite #(.DATA_W(32), .MASK(FB_MASK)) u_fb_pend (
        .clk(ACLK), .rst_n(ARESETN), .we(fbp_we), .be(bus.BYTEEN),
        .wdata(bus.WDATA), .q(fb_pend)
    );

    assign disp_enable = ctrl_q[CTRL_ENABLE];

    // A pending-register write in the vblank cycle re-arms UPD_PEND; the latch takes the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            upd_pend  <= 1'b0;
            fb_addr   <= '0;
            vblank    <= 1'b0;
            frame_cnt <= '0;
            uflow_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            if (vblank_start && upd_pend) fb_addr <= fb_pend;

            if (fbp_we && (bus.BYTEEN != 4'b0)) upd_pend <= 1'b1;
            else if (vblank_start)              upd_pend <= 1'b0;

            if (vblank_start)
                vblank <= 1'b1;
            else if (stat_we && bus.BYTEEN[0] && bus.WDATA[STAT_VBLANK])
                vblank <= 1'b0;

            if (vblank_start) frame_cnt <= frame_cnt + 32'd1;

            if (ufc_we)                       uflow_cnt <= UFLOW_W'(underflow);
            else if (underflow && ~&uflow_cnt) uflow_cnt <= uflow_cnt + 1'b1;

            irq <= ctrl_q[CTRL_IRQ_EN] & vblank;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.RDADDR[7:0])
            OFF_CTRL:          rd_val = ctrl_q;
            OFF_FB_PEND:       rd_val = fb_pend;
            OFF_FB_ACTIVE:     rd_val = fb_addr;
            OFF_STATUS: begin
                rd_val[STAT_VBLANK]   = vblank;
                rd_val[STAT_UPD_PEND] = upd_pend;
            end
            OFF_FRAME_CNT:     rd_val = frame_cnt;
            OFF_UNDERFLOW_CNT: rd_val = 32'(uflow_cnt);
            default:           rd_val = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)      rdata <= '0;
        else if (bus.RDEN) rdata <= win_hit(bus.RDADDR) ? rd_val : 32'd0;
    end

    assign bus.RDATA = rdata;
endmodule

// File: tb/tb_disp_regctrl.sv
// Scoreboard bench for disp_regctrl: driver feeds a register-level model, monitor compares outputs.
module tb_disp_regctrl;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        vblank_start = 1'b0;
    logic        underflow = 1'b0;
    logic        disp_enable;
    logic [31:0] fb_addr;
    logic        irq;

    disp_regctrl_if bus();

    disp_regctrl dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus.slave),
        .vblank_start(vblank_start), .underflow(underflow),
        .disp_enable(disp_enable), .fb_addr(fb_addr), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] fb;
        logic        irq;
        logic        en;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference state, register-map view
    logic        m_en, m_irqen, m_upd, m_vblank, m_irq;
    logic [31:0] m_pend, m_active, m_frame, m_rdata;
    int          m_uf;

    logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h02};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00:   return {30'b0, m_irqen, m_en};
            8'h04:   return m_pend;
            8'h08:   return m_active;
            8'h0C:   return {30'b0, m_upd, m_vblank};
            8'h10:   return m_frame;
            8'h14:   return 32'(m_uf);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_upd = 0; m_vblank = 0; m_irq = 0;
        m_pend = 0; m_active = 0; m_frame = 0; m_rdata = 0; m_uf = 0;
    endtask

    task automatic model_step(input logic wr, input logic [15:0] wa, input logic [3:0] be,
                              input logic [31:0] wd, input logic rd, input logic [15:0] ra,
                              input logic vb, input logic uf);
        logic [31:0] old_pend;
        logic old_upd, old_vb, upd_set, vb_clr, uf_clr;
        old_pend = m_pend; old_upd = m_upd; old_vb = m_vblank;
        upd_set = 0; vb_clr = 0; uf_clr = 0;
        if (rd) m_rdata = (ra[15:8] == 8'h20) ? model_read(ra[7:0]) : 32'h0;
        m_irq = m_irqen & old_vb;
        if (wr && wa[15:8] == 8'h20) begin
            case (wa[7:0])
                8'h00: if (be[0]) begin m_en = wd[0]; m_irqen = wd[1]; end
                8'h04: begin
                    for (int b = 0; b < 4; b++) if (be[b]) m_pend[8*b +: 8] = wd[8*b +: 8];
                    m_pend[2:0] = 3'b0;
                    upd_set = (be != 4'b0);
                end
                8'h0C: vb_clr = be[0] & wd[0];
                8'h14: uf_clr = 1;
                default: ;
            endcase
        end
        if (vb) begin
            m_frame = m_frame + 32'd1;
            if (old_upd) m_active = old_pend;
        end
        m_upd    = upd_set | (old_upd & ~vb);
        m_vblank = vb | (old_vb & ~vb_clr);
        if (uf_clr)                  m_uf = uf ? 1 : 0;
        else if (uf && m_uf < 65535) m_uf = m_uf + 1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.rdata = m_rdata; e.fb = m_active; e.irq = m_irq; e.en = m_en;
        q.push_back(e);
    endtask

    task automatic step(input logic wr, input logic [15:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic rd, input logic [15:0] ra,
                        input logic vb, input logic uf);
        @(negedge ACLK);
        ARESETN = 1'b1;
        bus.WREN = wr; bus.WRADDR = wa; bus.BYTEEN = be; bus.WDATA = wd;
        bus.RDEN = rd; bus.RDADDR = ra;
        vblank_start = vb; underflow = uf;
        model_step(wr, wa, be, wd, rd, ra, vb, uf);
        push_exp();
    endtask

    task automatic idle();
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 0, 0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d, input logic vb);
        step(1, {8'h20, off}, be, d, 0, 16'h0, vb, 0);
    endtask

    task automatic rd(input logic [7:0] off);
        step(0, 16'h0, 4'h0, 32'h0, 1, {8'h20, off}, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            ARESETN = 1'b0;
            bus.WREN = 0; bus.WRADDR = 0; bus.BYTEEN = 0; bus.WDATA = 0;
            bus.RDEN = 0; bus.RDADDR = 0; vblank_start = 0; underflow = 0;
            model_reset();
            push_exp();
        end
    endtask

    // Monitor: compares every output against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge ACLK);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata", bus.RDATA, e.rdata);
                chk("fb_addr", fb_addr, e.fb);
                chk("irq", 32'(irq), 32'(e.irq));
                chk("disp_enable", 32'(disp_enable), 32'(e.en));
            end
        end
    end

    initial begin
        bus.WREN = 0; bus.WRADDR = 0; bus.BYTEEN = 0; bus.WDATA = 0;
        bus.RDEN = 0; bus.RDADDR = 0;
        model_reset();
        do_reset(3);
        for (int i = 0; i < 6; i++) rd(offs[i]);
        idle();

        // Framebuffer latch
        wr(8'h04, 4'hF, 32'h1000_0007, 0);
        rd(8'h04); rd(8'h0C); rd(8'h08);
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 1, 0);
        rd(8'h0C); rd(8'h08); idle();

        // Byte-enabled write
        wr(8'h04, 4'h3, 32'hAABB_CCDD, 0);
        rd(8'h04);

        // Pending write coinciding with vblank
        wr(8'h04, 4'hF, 32'h2000_0000, 0);
        wr(8'h04, 4'hF, 32'h3000_0000, 1);
        rd(8'h0C); rd(8'h08);
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 1, 0);
        rd(8'h08); idle();

        // Interrupt path
        wr(8'h00, 4'h1, 32'h0000_0003, 0);
        wr(8'h0C, 4'h1, 32'h1, 0);
        idle();
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 1, 0);
        idle(); idle();
        wr(8'h0C, 4'h1, 32'h1, 1);
        rd(8'h0C); idle();
        wr(8'h0C, 4'h1, 32'h1, 0);
        idle(); idle(); rd(8'h0C);
        rd(8'h00);

        // Randomized traffic, including out-of-window and unmapped accesses
        for (int i = 0; i < 400; i++) begin
            logic w, r, v, u;
            logic [7:0] hi_w, hi_r;
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 0);
            v = ($urandom_range(0, 7) == 0);
            u = ($urandom_range(0, 3) == 0);
            hi_w = ($urandom_range(0, 9) == 0) ? 8'h21 : 8'h20;
            hi_r = ($urandom_range(0, 9) == 0) ? 8'h30 : 8'h20;
            step(w, {hi_w, offs[$urandom_range(0, 7)]}, 4'($urandom), $urandom,
                 r, {hi_r, offs[$urandom_range(0, 7)]}, v, u);
        end

        // Mid-frame reset, then a vblank that must latch nothing
        wr(8'h04, 4'hF, 32'h5555_5550, 0);
        wr(8'h00, 4'h1, 32'h3, 1);
        do_reset(2);
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 1, 0);
        rd(8'h08); rd(8'h0C); rd(8'h10); idle();

        // Underflow saturation and clear-with-pulse
        for (int i = 0; i < 70000; i++) step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 0, 1);
        rd(8'h14);
        step(1, 16'h2014, 4'h0, 32'h0, 0, 16'h0, 0, 1);
        rd(8'h14); idle();

        // Frame counter wrap via backdoor preload
        @(negedge ACLK);
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        m_frame = 32'hFFFF_FFFF;
        rd(8'h10);
        step(0, 16'h0, 4'h0, 32'h0, 0, 16'h0, 1, 0);
        rd(8'h10); idle();

        repeat (3) @(negedge ACLK);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
